// File: rtl/game_pkg.sv
// Shared constants for the flappy-style game controller: state codes,
// screen geometry, LFSR seed and the pipe-gap generator step.
package game_pkg;

   localparam int unsigned SCREEN_W  = 640;
   localparam int unsigned SCREEN_H  = 480;
   localparam int unsigned GAP_BASE  = 60;
   localparam int unsigned GAP_RESET = 180;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PLAY = 2'd1;
   localparam logic [1:0] ST_DEAD = 2'd2;

   localparam logic [7:0] LFSR_SEED = 8'hA5;

   // Fibonacci step for x^8+x^6+x^5+x^4+1
   function automatic logic [7:0] lfsr_next(input logic [7:0] q);
      return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
   endfunction

endpackage

// File: rtl/frame_tick.sv
// Free-running divider: tick is high for one cycle when the count reaches TICK_DIV-1.
module frame_tick #(
   parameter int unsigned TICK_DIV = 1666667
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned   CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: IDLE/PLAY/DEAD flow, scrolling pipe, collision check,
// scoring and frame/flap strobes toward the bird physics block.
module game_ctrl
   import game_pkg::*;
#(
   parameter int unsigned TICK_DIV   = 1666667,
   parameter int unsigned DEAD_TICKS = 30,
   parameter int unsigned BIRD_X     = 160,
   parameter int unsigned PIPE_W     = 60,
   parameter int unsigned GAP_H      = 120,
   parameter int unsigned SCROLL     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flap,
   input  logic signed [9:0] bird_y,
   output logic              phys_rst,
   output logic              phys_tick,
   output logic              flap_pulse,
   output logic [1:0]        state,
   output logic [9:0]        pipe_x,
   output logic [9:0]        gap_y,
   output logic [7:0]        score,
   output logic              game_over
);

   localparam int unsigned     DW         = (DEAD_TICKS > 0) ? $clog2(DEAD_TICKS + 1) : 1;
   localparam logic [DW-1:0]   DEAD_MAX   = DW'(DEAD_TICKS);
   localparam logic [9:0]      PIPE_START = 10'(SCREEN_W);
   localparam logic [9:0]      SCROLL_PX  = 10'(SCROLL);
   localparam logic [10:0]     BIRD_X11   = 11'(BIRD_X);
   localparam logic [10:0]     PIPE_W11   = 11'(PIPE_W);
   localparam logic [10:0]     GAP_H11    = 11'(GAP_H);
   localparam logic signed [10:0] TOP_Y   = signed'(11'(SCREEN_H));

   logic          tick;
   logic          flap_q;
   logic          flap_edge;
   logic [7:0]    lfsr;
   logic [DW-1:0] dead_cnt;
   logic [9:0]    gap_new;

   logic [1:0]    state_n;
   logic [9:0]    pipe_x_n;
   logic [9:0]    gap_y_n;
   logic [7:0]    score_n;
   logic [DW-1:0] dead_cnt_n;
   logic          flap_pulse_n;

   logic signed [10:0] by_s;
   logic signed [10:0] gap_lo_s;
   logic signed [10:0] gap_hi_s;
   logic [10:0]        px_w;
   logic               in_col;
   logic               collide;

   frame_tick #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign flap_edge = flap & ~flap_q;
   assign phys_rst  = (state == ST_IDLE);
   assign phys_tick = tick & (state == ST_PLAY);
   assign gap_new   = 10'(GAP_BASE) + {2'b00, lfsr};

   // Collision geometry, widened to 11 bits so pipe_x+PIPE_W cannot wrap
   assign by_s     = {bird_y[9], bird_y};
   assign gap_lo_s = {1'b0, gap_y};
   assign gap_hi_s = {1'b0, gap_y} + GAP_H11;
   assign px_w     = {1'b0, pipe_x};
   assign in_col   = (BIRD_X11 >= px_w) && (BIRD_X11 < px_w + PIPE_W11);
   assign collide  = (state == ST_PLAY) &&
                     ((by_s <= 11'sd0) || (by_s >= TOP_Y) ||
                      (in_col && ((by_s < gap_lo_s) || (by_s > gap_hi_s))));

   always_comb begin
      state_n      = state;
      pipe_x_n     = pipe_x;
      gap_y_n      = gap_y;
      score_n      = score;
      dead_cnt_n   = dead_cnt;
      flap_pulse_n = 1'b0;
      case (state)
         ST_IDLE: begin
            if (flap_edge) begin
               state_n      = ST_PLAY;
               pipe_x_n     = PIPE_START;
               gap_y_n      = gap_new;
               score_n      = 8'd0;
               flap_pulse_n = 1'b1;
            end
         end
         ST_PLAY: begin
            // Collision outranks both a flap and a pipe wrap on the same cycle
            if (collide) begin
               state_n    = ST_DEAD;
               dead_cnt_n = '0;
            end else begin
               flap_pulse_n = flap_edge;
               if (tick) begin
                  if (pipe_x < SCROLL_PX) begin
                     pipe_x_n = PIPE_START;
                     gap_y_n  = gap_new;
                     score_n  = (score == 8'hFF) ? score : score + 8'd1;
                  end else begin
                     pipe_x_n = pipe_x - SCROLL_PX;
                  end
               end
            end
         end
         ST_DEAD: begin
            if (flap_edge && (dead_cnt == DEAD_MAX)) begin
               state_n = ST_IDLE;
            end else if (tick && (dead_cnt < DEAD_MAX)) begin
               dead_cnt_n = dead_cnt + DW'(1);
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         pipe_x     <= PIPE_START;
         gap_y      <= 10'(GAP_RESET);
         score      <= 8'd0;
         dead_cnt   <= '0;
         flap_pulse <= 1'b0;
         game_over  <= 1'b0;
         flap_q     <= 1'b0;
         lfsr       <= LFSR_SEED;
      end else begin
         state      <= state_n;
         pipe_x     <= pipe_x_n;
         gap_y      <= gap_y_n;
         score      <= score_n;
         dead_cnt   <= dead_cnt_n;
         flap_pulse <= flap_pulse_n;
         game_over  <= (state_n == ST_DEAD);
         flap_q     <= flap;
         lfsr       <= lfsr_next(lfsr);
      end
   end

endmodule
